// File: rtl/ps2_codes_pkg.sv
// PS/2 scan-code constants and sequence-FSM encoding shared by the key decoder.
package ps2_codes_pkg;

  localparam int CODE_W = 9;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Keyboard housekeeping bytes (ACK, BAT pass, echo, error responses).
  localparam int N_IGNORED = 7;
  localparam logic [N_IGNORED-1:0][7:0] PS2_IGNORED =
    {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } seq_state_e;

  function automatic logic is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_IGNORED; i++)
      if (b == PS2_IGNORED[i]) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_match.sv
// Maps a 9-bit {ext, scan} code to a one-hot slot vector; lowest slot wins on duplicates.
module ps2_key_match
  import ps2_codes_pkg::*;
#(
  parameter int                      NUM_KEYS  = 3,
  parameter logic [9*NUM_KEYS-1:0]   KEY_CODES = {9'h174, 9'h16B, 9'h05A}
) (
  input  logic [CODE_W-1:0]   code_i,
  output logic [NUM_KEYS-1:0] match_o
);

  // Scan from the top so the last (lowest-index) hit overwrites higher ones.
  always_comb begin
    match_o = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (code_i == KEY_CODES[9*i +: 9]) begin
        match_o    = '0;
        match_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 make/break sequence decoder with per-key down/make/repeat/break tracking.
module ps2_key_decoder
  import ps2_codes_pkg::*;
#(
  parameter int                    NUM_KEYS       = 3,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h174, 9'h16B, 9'h05A},
  parameter int                    TIMEOUT_CYCLES = 100_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_make,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [NUM_KEYS-1:0] key_break,
  output logic                event_valid,
  output logic [CODE_W-1:0]   event_code,
  output logic                event_break,
  output logic                seq_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done, done_brk;
  logic [CODE_W-1:0]   done_code;
  logic [NUM_KEYS-1:0] match;

  logic [NUM_KEYS-1:0] down_q, down_d, make_q, make_d;
  logic [NUM_KEYS-1:0] rep_q, rep_d, brk_q, brk_d;
  logic                ev_valid_q, ev_brk_q, ev_brk_d, err_q, err_d;
  logic [CODE_W-1:0]   ev_code_q, ev_code_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done      = 1'b0;
    done_brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    done_code = {(state_q == ST_EXT) || (state_q == ST_EXT_BRK), received_data};
    err_d     = 1'b0;
    if (received_data_en) begin
      cnt_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (received_data == PS2_EXT)      state_d = ST_EXT;
          else if (received_data == PS2_BRK) state_d = ST_BRK;
          else if (!is_ignored(received_data)) done = 1'b1;
        end
        ST_EXT: begin
          if (received_data == PS2_BRK)      state_d = ST_EXT_BRK;
          else if (received_data != PS2_EXT) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          if (received_data != PS2_EXT && received_data != PS2_BRK) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == TO_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  ps2_key_match #(
    .NUM_KEYS (NUM_KEYS),
    .KEY_CODES(KEY_CODES)
  ) u_match (
    .code_i (done_code),
    .match_o(match)
  );

  always_comb begin
    make_d    = '0;
    rep_d     = '0;
    brk_d     = '0;
    if (done && !done_brk) begin
      make_d = match & ~down_q;
      rep_d  = match & down_q;
    end
    if (done && done_brk) brk_d = match & down_q;
    down_d    = (down_q | make_d) & ~brk_d;
    ev_code_d = done ? done_code : ev_code_q;
    ev_brk_d  = done ? done_brk  : ev_brk_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      down_q     <= '0;
      make_q     <= '0;
      rep_q      <= '0;
      brk_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= '0;
      ev_brk_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      down_q     <= down_d;
      make_q     <= make_d;
      rep_q      <= rep_d;
      brk_q      <= brk_d;
      ev_valid_q <= done;
      ev_code_q  <= ev_code_d;
      ev_brk_q   <= ev_brk_d;
      err_q      <= err_d;
    end
  end

  assign key_down    = down_q;
  assign key_make    = make_q;
  assign key_repeat  = rep_q;
  assign key_break   = brk_q;
  assign event_valid = ev_valid_q;
  assign event_code  = ev_code_q;
  assign event_break = ev_brk_q;
  assign seq_error   = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized scoreboard bench for ps2_key_decoder against a flag-based sequence model.
module tb_ps2_key_decoder;

  localparam int NK = 3;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rd;
  logic          rd_en;
  logic [NK-1:0] key_down, key_make, key_repeat, key_break;
  logic          event_valid, event_break, seq_error;
  logic [8:0]    event_code;

  ps2_key_decoder #(
    .NUM_KEYS      (NK),
    .KEY_CODES     ({9'h174, 9'h16B, 9'h05A}),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLOCK_50        (clk),
    .reset           (rst),
    .received_data   (rd),
    .received_data_en(rd_en),
    .key_down        (key_down),
    .key_make        (key_make),
    .key_repeat      (key_repeat),
    .key_break       (key_break),
    .event_valid     (event_valid),
    .event_code      (event_code),
    .event_break     (event_break),
    .seq_error       (seq_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic [8:0]    code;
    logic          brk;
    logic [NK-1:0] mk, rp, bk, dn;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: pending-prefix flags, held keys, idle cycles since last byte.
  bit            m_ext, m_brk;
  logic [NK-1:0] m_down;
  int            gap;
  logic [8:0]    codes [NK];

  function automatic bit ignored(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    int   hit;
    gap = 0;
    if (b == 8'hE0) begin
      if (!m_brk) m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (!m_ext && !m_brk && ignored(b)) begin
    end else begin
      e      = '0;
      e.code = {m_ext, b};
      e.brk  = m_brk;
      hit    = -1;
      for (int i = 0; i < NK; i++)
        if (hit < 0 && codes[i] == e.code) hit = i;
      if (hit >= 0) begin
        if (!m_brk) begin
          if (m_down[hit]) e.rp[hit] = 1'b1;
          else begin e.mk[hit] = 1'b1; m_down[hit] = 1'b1; end
        end else if (m_down[hit]) begin
          e.bk[hit] = 1'b1;
          m_down[hit] = 1'b0;
        end
      end
      e.dn  = m_down;
      m_ext = 1'b0;
      m_brk = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    rd    = b;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    model_byte(b);
  endtask

  task automatic idle(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      gap++;
      if ((m_ext || m_brk) && gap == T) begin
        e     = '0;
        e.err = 1'b1;
        q.push_back(e);
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_down = '0;
    gap    = 0;
    q.delete();
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (event_valid || seq_error) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: event_valid=%0b seq_error=%0b code=%h, none expected",
                 event_valid, seq_error, event_code);
      end else begin
        me = q.pop_front();
        if (seq_error !== me.err || event_valid !== !me.err) begin
          fails++;
          $display("FAIL kind: got valid=%0b err=%0b, want err=%0b", event_valid, seq_error, me.err);
        end else if (!me.err) begin
          checks++;
          if (event_code !== me.code || event_break !== me.brk) begin
            fails++;
            $display("FAIL event: got code=%h brk=%0b, want code=%h brk=%0b",
                     event_code, event_break, me.code, me.brk);
          end
          checks++;
          if ({key_make, key_repeat, key_break, key_down} !== {me.mk, me.rp, me.bk, me.dn}) begin
            fails++;
            $display("FAIL keys: got mk=%b rp=%b bk=%b dn=%b, want mk=%b rp=%b bk=%b dn=%b",
                     key_make, key_repeat, key_break, key_down, me.mk, me.rp, me.bk, me.dn);
          end
        end
      end
    end else begin
      checks++;
      if ({key_make, key_repeat, key_break} !== '0) begin
        fails++;
        $display("FAIL stray_pulse: mk=%b rp=%b bk=%b without event", key_make, key_repeat, key_break);
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         r;
    codes  = '{9'h05A, 9'h16B, 9'h174};
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_down = '0;
    gap    = 0;
    rst    = 1'b1;
    rd     = 8'h00;
    rd_en  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_down, key_make, key_repeat, key_break, event_valid, event_code, event_break, seq_error} !== '0) begin
      fails++;
      $display("FAIL reset_state: down=%b valid=%0b code=%h brk=%0b err=%0b, want all zero",
               key_down, event_valid, event_code, event_break, seq_error);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios.
    strobe(8'h5A); idle(3);
    strobe(8'h5A); idle(1); strobe(8'hF0); strobe(8'h5A); idle(2);
    strobe(8'hE0); strobe(8'h6B); idle(2);
    strobe(8'hE0); strobe(8'h6B); idle(2);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h6B); idle(2);
    strobe(8'hE0); strobe(8'h74); strobe(8'h5A); idle(1);
    strobe(8'hF0); strobe(8'h5A); idle(2);
    strobe(8'hE0); idle(T + 2); strobe(8'h74); idle(2);
    strobe(8'hE0); idle(T - 1); strobe(8'h74); idle(2);
    strobe(8'hE0); idle(T); strobe(8'h5A); idle(2);
    strobe(8'hAA); idle(2);
    strobe(8'hF0); strobe(8'hE0); strobe(8'h5A); idle(2);
    strobe(8'hE0); strobe(8'hE0); strobe(8'h74); idle(2);
    strobe(8'hF0); idle(3);
    do_reset();
    strobe(8'h5A); idle(3);

    // Randomized byte streams with gaps straddling the timeout.
    for (int n = 0; n < 700; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2:       b = 8'hF0;
        3:       b = 8'h5A;
        4:       b = 8'h6B;
        5:       b = 8'h74;
        6:       b = 8'hAA;
        7:       b = 8'hFA;
        default: b = 8'($urandom_range(0, 255));
      endcase
      strobe(b);
      r = int'($urandom_range(0, 19));
      if (r < 15) idle(r % 3);
      else idle(T - 2 + (r - 15));
      if (n == 350) begin
        idle(T + 3);
        do_reset();
      end
    end

    idle(T + 4);
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected outputs never appeared, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter NUM_KEYS, default 3: number of tracked keys, legal range 1..16.
REQ-002 Parameter KEY_CODES, width 9*NUM_KEYS, default {9'h174, 9'h16B, 9'h05A}: per-key code in slot i (bits 9i+8..9i); bit 8 = extended (E0) flag, bits 7:0 = scan code; default slots: 0 Enter, 1 Left, 2 Right.
REQ-003 Parameter TIMEOUT_CYCLES, default 100_000: partial-sequence abort limit, 2 ms at 50 MHz; legal range 2..2^24.
REQ-004 CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 received_data  input  8  byte from PS2_Controller; valid only while received_data_en is high.
REQ-007 received_data_en  input  1  single-cycle byte strobe.
REQ-008 key_down  output  NUM_KEYS  level; bit i is high while key i is held.
REQ-009 key_make  output  NUM_KEYS  one-cycle pulse on the first press of key i.
REQ-010 key_repeat  output  NUM_KEYS  one-cycle pulse on a typematic make while key i is already down.
REQ-011 key_break  output  NUM_KEYS  one-cycle pulse on the release of key i.
REQ-012 event_valid  output  1  one-cycle pulse for every completed make or break, tracked or not.
REQ-013 event_code  output  9  {ext, scan} of the last completed event; held between events.
REQ-014 event_break  output  1  high when event_code is a break; held between events.
REQ-015 seq_error  output  1  one-cycle pulse when a partial sequence times out.

Function
REQ-016 Sequence FSM has four states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-017 State changes only on cycles where received_data_en=1; the timeout rule is the only exception.
REQ-018 IDLE transitions on a byte: E0 goes to EXT; F0 goes to BRK; 00, AA, EE, FA, FC, FE, FF are ignored and stay IDLE; any other byte b completes make {0,b} and stays IDLE.
REQ-019 EXT transitions on a byte: F0 goes to EXT_BRK; E0 stays EXT; any other byte b completes make {1,b} and goes to IDLE.
REQ-020 BRK transitions on a byte: E0 or F0 stays BRK; any other byte b completes break {0,b} and goes to IDLE.
REQ-021 EXT_BRK transitions on a byte: E0 or F0 stays EXT_BRK; any other byte b completes break {1,b} and goes to IDLE.
REQ-022 Latency: a completing byte strobed in cycle t drives the event_* outputs and the key_* outputs in cycle t+1; all outputs are registered.
REQ-023 Key match: an event code matches slot i when it equals KEY_CODES slot i; if several slots hold the same code, only the lowest-index slot is affected.
REQ-024 Make on key i with key_down[i]=0: key_make[i] pulses and key_down[i] goes to 1.
REQ-025 Make on key i with key_down[i]=1: key_repeat[i] pulses and key_down[i] is unchanged.
REQ-026 Break on key i with key_down[i]=1: key_break[i] pulses and key_down[i] goes to 0.
REQ-027 Break on key i with key_down[i]=0: no key_* pulse; event_valid still pulses.
REQ-028 Unmatched codes: only event_valid, event_code and event_break update.
REQ-029 Timeout counter clears on every strobe and counts in any non-IDLE state.
REQ-030 When the timeout counter reaches TIMEOUT_CYCLES-1 with no strobe, the FSM returns to IDLE, seq_error pulses in the next cycle, and no event is produced.
REQ-031 A strobe in the same cycle as timeout expiry wins: the byte is processed normally and seq_error does not pulse.
REQ-032 Multiple keys may be down simultaneously, each tracked independently.

Reset
REQ-033 reset=1 at a rising edge forces IDLE and clears the timeout counter.
REQ-034 reset=1 drives key_down, key_make, key_repeat, key_break, event_valid, event_code, event_break and seq_error to 0 in the next cycle.
REQ-035 reset overrides a simultaneous strobe; a sequence in progress at reset is discarded.

Structure
REQ-036 Package ps2_codes_pkg holds: PS2_EXT=8'hE0, PS2_BRK=8'hF0, the ignored-byte list, 9-bit code width, and FSM state encoding.
REQ-037 Sub-module ps2_key_match (combinational) maps a 9-bit code to a one-hot NUM_KEYS match vector with lowest-index priority; all other logic stays in ps2_key_decoder.

Verification
REQ-038 Byte 5A -> key_make[0]=1 for one cycle, key_down=3'b001, event_code=9'h05A, event_break=0.
REQ-039 Bytes E0,6B then E0,6B then E0,F0,6B -> key_make[1] pulse, then key_repeat[1] pulse, then key_break[1] pulse with key_down[1]=0.
REQ-040 Bytes E0,74 then 5A, then F0,5A -> key_down=3'b101 after both makes, then 3'b100 after the break.
REQ-041 Byte E0 followed by TIMEOUT_CYCLES idle cycles -> seq_error pulse, no event; then byte 74 -> event_code=9'h074, no key pulse.
REQ-042 Bytes F0 then reset asserted, then 5A -> key_break stays 0, make on key 0 recognised.
REQ-043 Byte strobed exactly at timeout expiry; byte AA in IDLE -> byte processed, seq_error=0; AA produces no event.
